// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor. It processes one bit per clock, LSB first,
// through a single full-adder stage with a carry flip-flop. A start/busy/done
// handshake frames each operation. Subtraction is formed as a + ~b + 1, so
// cout reads as "no borrow" (a >= b unsigned) in subtract mode.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // The bit counter only has to reach WIDTH-1. Keep it at least one bit wide
  // so that WIDTH=1 still elaborates cleanly.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers, running carry and bit counter
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Partial result collects bits from the MSB end. The visible result
  // registers are separate, so a half-built sum is never shown.
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_bit;
  logic             a_bit, b_bit;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] res_shift;

  // A new request is taken only when the engine is not mid-operation.
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_BIT);

  // The full-adder stage works on the LSBs of the operand shift registers.
  assign a_bit = a_sh_q[0];
  assign b_bit = b_sh_q[0];
  assign s_bit = a_bit ^ b_bit ^ carry_q;
  assign c_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  // The new sum bit enters the result at the MSB. After WIDTH shifts, bit 0
  // has reached position 0. A one-bit result is just the sum bit itself.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = s_bit;
    end else begin : g_res_wn
      assign res_shift = {s_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, and DONE can chain
  // straight into a new RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state, so busy and done are
  // mutually exclusive by construction.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: load operands on accept, otherwise step one bit per
  // RUN cycle, and latch the visible result on the last bit.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      carry_d = c_bit;
      cnt_d   = cnt_q + CNT_ONE;
      res_d   = res_shift;
      if (last_bit) begin
        // On the last bit, carry_q is the carry into the MSB and c_bit is the
        // carry out of it. Overflow is their XOR.
        sum_d  = res_shift;
        cout_d = c_bit;
        ovf_d  = carry_q ^ c_bit;
      end
    end
  end

  // Datapath registers. Reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed and random checks of serial_adder at WIDTH = 1, 8 and 16.
// All outputs are sampled 1 ns after the rising edge.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;
  int overlap_count = 0;
  int stable_err = 0;

  // WIDTH = 8 instance
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ovf8;

  // WIDTH = 1 instance
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1, ovf1;

  // WIDTH = 16 instance
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16, ovf16;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Launches one WIDTH=8 operation and returns in the cycle where done is
  // high. After the accepting edge the operand inputs are scrambled. With
  // hold set, start also stays high for several RUN cycles.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cin_v,
                               input logic sub_v, input bit hold,
                               output int lat, output int busy_cycles, output time done_t);
    a8 = av; b8 = bv; cin8 = cin_v; sub8 = sub_v; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = ~av; b8 = bv ^ 8'h5a; cin8 = ~cin_v; sub8 = ~sub_v;
    if (!hold) start8 = 1'b0;
    lat = 0;
    busy_cycles = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 5) start8 = 1'b0;
      if (busy8) busy_cycles++;
      if (busy8 && done8) overlap_count++;
    end
    start8 = 1'b0;
    if (!done8) checkOutput("timeout8", 32'd0, 32'd1);
    done_t = $time;
  endtask

  // Full directed WIDTH=8 case: result, flags, latency, busy length, and
  // that done lasts only one cycle.
  task automatic runCase8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cin_v, input logic sub_v, input bit hold,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat, bc;
    time t;
    applyStimulus(av, bv, cin_v, sub_v, hold, lat, bc, t);
    checkOutput({tag, ".sum"}, 32'(sum8), 32'(exp_sum));
    checkOutput({tag, ".cout"}, 32'(cout8), 32'(exp_cout));
    checkOutput({tag, ".ovf"}, 32'(ovf8), 32'(exp_ovf));
    checkOutput({tag, ".latency"}, 32'(lat), 32'd8);
    checkOutput({tag, ".busy_cycles"}, 32'(bc), 32'd8);
    @(posedge clk); #1;
    checkOutput({tag, ".done_drop"}, 32'(done8), 32'd0);
    checkOutput({tag, ".sum_hold"}, 32'(sum8), 32'(exp_sum));
  endtask

  // One WIDTH=1 operation. Expected {cout,sum} is the full-adder truth table.
  task automatic applyStimulusW1(input logic av, input logic bv, input logic cv);
    int lat;
    logic [1:0] exp;
    exp = 2'(av) + 2'(bv) + 2'(cv);
    a1 = av; b1 = bv; cin1 = cv; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w1.latency", 32'(lat), 32'd1);
    checkOutput("w1.sum_cout", 32'({cout1, sum1}), 32'(exp));
    checkOutput("w1.ovf", 32'(ovf1), 32'(cv ^ exp[1]));
  endtask

  // One random WIDTH=16 operation checked against integer arithmetic. The
  // visible sum must not change while the operation is running.
  task automatic applyStimulusW16(input logic [15:0] prev_sum);
    logic [15:0] av, bv, exp_sum;
    logic        cv, sv, exp_cout, exp_ovf;
    logic [16:0] full;
    int lat;
    av = 16'($urandom);
    bv = 16'($urandom);
    cv = 1'($urandom);
    sv = 1'($urandom);
    if (sv) begin
      full     = {1'b0, av} + {1'b0, ~bv} + 17'd1;
      exp_cout = (av >= bv);
      exp_ovf  = (av[15] != bv[15]) && (full[15] != av[15]);
    end else begin
      full     = {1'b0, av} + {1'b0, bv} + 17'(cv);
      exp_cout = full[16];
      exp_ovf  = (av[15] == bv[15]) && (full[15] != av[15]);
    end
    exp_sum = full[15:0];
    a16 = av; b16 = bv; cin16 = cv; sub16 = sv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = ~av; b16 = ~bv;
    lat = 0;
    while (!done16 && lat < 40) begin
      if (sum16 !== prev_sum) stable_err++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat != 16 || sum16 !== exp_sum || cout16 !== exp_cout || ovf16 !== exp_ovf) begin
      checkOutput("w16.sum", 32'(sum16), 32'(exp_sum));
      checkOutput("w16.cout", 32'(cout16), 32'(exp_cout));
      checkOutput("w16.ovf", 32'(ovf16), 32'(exp_ovf));
      checkOutput("w16.latency", 32'(lat), 32'd16);
    end else begin
      check_count++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc, done_seen;
    time t1, t2;
    logic [15:0] prev16;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy8), 32'd0);
    checkOutput("reset.done", 32'(done8), 32'd0);
    checkOutput("reset.sum", 32'(sum8), 32'd0);
    checkOutput("reset.cout", 32'(cout8), 32'd0);
    checkOutput("reset.ovf", 32'(ovf8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] WIDTH=1 truth table");
    for (int i = 0; i < 8; i++) begin
      applyStimulusW1(i[2], i[1], i[0]);
      @(posedge clk); #1;
    end

    $display("[TB] WIDTH=8 directed add/sub");
    runCase8("add_ff_01", 8'hff, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    runCase8("add_7f_01", 8'h7f, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    runCase8("add_12_34_c", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 8'h47, 1'b0, 1'b0);
    runCase8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hfe, 1'b0, 1'b0);
    runCase8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7f, 1'b1, 1'b1);
    runCase8("sub_cin_ign", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 8'hfe, 1'b0, 1'b0);
    runCase8("sub_00_00", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    runCase8("start_held", 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0);

    $display("[TB] WIDTH=8 back-to-back");
    applyStimulus(8'h7f, 8'h01, 1'b0, 1'b0, 1'b0, lat, bc, t1);
    checkOutput("b2b.first_sum", 32'(sum8), 32'h80);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, lat, bc, t2);
    checkOutput("b2b.second_sum", 32'(sum8), 32'h7f);
    checkOutput("b2b.second_flags", 32'({cout8, ovf8}), 32'b11);
    checkOutput("b2b.gap", 32'((t2 - t1) / 10), 32'd9);

    $display("[TB] WIDTH=8 reset mid-operation");
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst.busy", 32'(busy8), 32'd0);
    checkOutput("midrst.done", 32'(done8), 32'd0);
    checkOutput("midrst.sum", 32'(sum8), 32'd0);
    checkOutput("midrst.cout", 32'(cout8), 32'd0);
    checkOutput("midrst.ovf", 32'(ovf8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_seen++;
    end
    checkOutput("midrst.no_done", 32'(done_seen), 32'd0);
    runCase8("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 8'h47, 1'b0, 1'b0);

    $display("[TB] WIDTH=16 random");
    prev16 = sum16;
    for (int i = 0; i < 1000; i++) begin
      applyStimulusW16(prev16);
      prev16 = sum16;
    end
    checkOutput("w16.sum_stable", 32'(stable_err), 32'd0);
    checkOutput("w8.busy_done_overlap", 32'(overlap_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: adds two WIDTH-bit operands one bit per clock, LSB first, through a single registered full-adder stage with a carry flip-flop. It is the sequential successor to the combinational full adder, adding operand width, a subtract mode, signed overflow detection and a start/busy/done handshake. It sits beside the datapath wherever area matters more than latency.

## Interface

- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
- sub  input  1  0 = a + b + cin, 1 = a − b (cin ignored)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add mode, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- cout  output  1  carry-out (add); no-borrow flag, 1 when a ≥ b unsigned (sub)
- overflow  output  1  signed two's-complement overflow

## Operation

- Reset (async, any time, including mid-operation): state IDLE, bit counter 0, carry 0, operand shift registers 0, busy 0, done 0, sum 0, cout 0, overflow 0. An in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a into A-shift, (sub ? ~b : b) into B-shift, carry ← (sub ? 1 : cin), counter ← 0, go RUN. Otherwise stay.
  - RUN: each cycle compute s = A[0]^B[0]^carry, c = majority(A[0],B[0],carry); shift s into result register from the MSB end; shift A, B right; carry ← c; counter++. When counter = WIDTH−1 (last bit), go DONE. start is ignored in RUN.
  - DONE: done=1 for exactly one cycle. start=1 → accept new operation as from IDLE (go RUN); else go IDLE.
- Results: sum, cout, overflow update only on the edge that processes the last bit, and hold until the next completion or reset. The partial result is never visible on sum.
- cout = carry out of bit WIDTH−1.
- overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1); requires registering the carry into the MSB.
- Arithmetic is modulo 2^WIDTH; subtraction is a + ~b + 1.
- WIDTH=1: RUN lasts one cycle; overflow = carry-in XOR carry-out of that single bit.

## Timing

- Start accepted at edge E0 → busy high after E0 through edge E0+WIDTH; done high for the cycle after edge E0+WIDTH; sum/cout/overflow valid from that same edge.
- Latency start-edge to done-high: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles; back-to-back by asserting start during the done cycle.
- busy and done are never high together.
- Operands are captured; changes to a, b, cin, sub after the accepting edge have no effect.

## Test plan

- WIDTH=1, all 8 combinations of {a,b,cin}, sub=0 → {cout,sum} matches full-adder truth table; done 1 cycle after start edge.
- WIDTH=8 add: FF+01 cin0 → sum 00, cout 1, overflow 0; 7F+01 cin0 → sum 80, cout 0, overflow 1; 12+34 cin1 → sum 47, cout 0.
- WIDTH=8 sub: 05−07 → sum FE, cout 0, overflow 0; 80−01 → sum 7F, cout 1, overflow 1; cin=1 during sub has no effect.
- Handshake: start pulse at edge E0 → busy high for 8 cycles, done exactly one cycle after edge E0+8; start held high during RUN with different operands → ignored, result unchanged; start asserted in the done cycle → second result 9 cycles after the first.
- Reset mid-operation: assert rst 3 cycles into RUN (asynchronously, between edges) → busy, done, sum, cout, overflow go 0 immediately; no done pulse follows; the next start completes normally.
- Randomised WIDTH=16: 1000 random {a,b,cin,sub} → sum/cout/overflow match a reference model; sum stable between done pulses.
